// File: rtl/sipo_shift_reg_param.sv
// sipo_shift_reg_param
// Parametrised serial-in/parallel-out converter with a registered
// valid/ready output word, sticky overrun flag and optional even parity.
//
// Optional feature: define SIPO_PARITY_EN to make each frame WIDTH data bits
// followed by one even-parity bit. The parity bit is checked into parity_err
// and is not placed in pout. With the macro undefined the frame is WIDTH bits
// and parity_err is constant 0.
module sipo_shift_reg_param #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int             CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pout_valid_q, pout_valid_d;
    logic             overrun_q, overrun_d;
    logic             parity_err_q, parity_err_d;

    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] word;
    logic             word_perr;
    logic             last_bit;

    // Shift register contents after accepting sin, in the configured bit order
    always_comb begin
        if (MSB_FIRST) begin
            shift_next = {shift_q[WIDTH-2:0], sin};
        end else begin
            shift_next = {sin, shift_q[WIDTH-1:1]};
        end
    end

`ifdef SIPO_PARITY_EN
    // Last bit of the frame is the parity bit: data is already complete in
    // shift_q, and the frame is good when all bits XOR to zero.
    assign word      = shift_q;
    assign word_perr = ^{shift_q, sin};
`else
    // Last bit of the frame is the last data bit, so the word includes it.
    assign word      = shift_next;
    assign word_perr = 1'b0;
`endif

    assign last_bit = (cnt_q == CNT_LAST);

    // Next-state logic: bit assembly, output handshake, overrun and clear
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        pout_d       = pout_q;
        pout_valid_d = pout_valid_q;
        overrun_d    = overrun_q;
        parity_err_d = parity_err_q;

        // Consumer takes the held word; a same-edge completion re-asserts below.
        if (pout_valid_q && pout_ready) begin
            pout_valid_d = 1'b0;
        end

        if (clr) begin
            // Discards the partial word (and any bit offered this edge) but
            // leaves the completed word in pout untouched.
            cnt_d     = '0;
            shift_d   = '0;
            overrun_d = 1'b0;
        end else if (sin_valid) begin
            if (last_bit) begin
                cnt_d   = '0;
                shift_d = '0;
                if (!pout_valid_q || pout_ready) begin
                    pout_d       = word;
                    pout_valid_d = 1'b1;
                    parity_err_d = word_perr;
                end else begin
                    // Holding register still owned by the consumer: drop the word.
                    overrun_d = 1'b1;
                end
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                shift_d = shift_next;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            pout_q       <= pout_d;
            pout_valid_q <= pout_valid_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign pout       = pout_q;
    assign pout_valid = pout_valid_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;
    assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_shift_reg_param.sv
// Testbench for sipo_shift_reg_param: two instances (MSB-first and LSB-first)
// share one stimulus stream and are compared every cycle against a frame-level
// reference model built from a queue of received bits.
module tb_sipo_shift_reg_param;
    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         clr = 1'b0;
    logic         pout_ready = 1'b0;
    logic [W-1:0] pout_m, pout_l;
    logic         pv_m, pv_l, busy_m, busy_l, ovr_m, ovr_l, pe_m, pe_l;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_bits[$];
    logic [W-1:0] m_msb, m_lsb;
    bit           m_pv, m_ovr, m_pe;

    always #5 clk = ~clk;

    sipo_shift_reg_param #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready),
        .busy(busy_m), .overrun(ovr_m), .parity_err(pe_m)
    );

    sipo_shift_reg_param #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready),
        .busy(busy_l), .overrun(ovr_l), .parity_err(pe_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_msb = '0;
        m_lsb = '0;
        m_pv  = 1'b0;
        m_ovr = 1'b0;
        m_pe  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pout_msb"}, 32'(pout_m), 32'(m_msb));
        chk({tag, "_pout_lsb"}, 32'(pout_l), 32'(m_lsb));
        chk({tag, "_pv_msb"}, 32'(pv_m), 32'(m_pv));
        chk({tag, "_pv_lsb"}, 32'(pv_l), 32'(m_pv));
        chk({tag, "_busy_msb"}, 32'(busy_m), 32'(m_bits.size() != 0));
        chk({tag, "_busy_lsb"}, 32'(busy_l), 32'(m_bits.size() != 0));
        chk({tag, "_ovr_msb"}, 32'(ovr_m), 32'(m_ovr));
        chk({tag, "_ovr_lsb"}, 32'(ovr_l), 32'(m_ovr));
        chk({tag, "_perr_msb"}, 32'(pe_m), 32'(m_pe));
        chk({tag, "_perr_lsb"}, 32'(pe_l), 32'(m_pe));
    endtask

    // Apply one clock of stimulus, advance the model, check all outputs.
    task automatic cycle(input bit sv, input bit s, input bit rdy, input bit c);
        logic [W-1:0] wm, wl;
        bit           par, pv_old;
        sin_valid  = sv;
        sin        = s;
        pout_ready = rdy;
        clr        = c;
        @(posedge clk);
        pv_old = m_pv;
        if (pv_old && rdy) m_pv = 1'b0;
        if (c) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (sv) begin
            m_bits.push_back(s);
            if (m_bits.size() == L) begin
                wm  = '0;
                wl  = '0;
                par = 1'b0;
                for (int i = 0; i < W; i++) begin
                    if (m_bits[i]) begin
                        wm = wm + (W'(1) << (W - 1 - i));
                        wl = wl + (W'(1) << i);
                    end
                end
                for (int i = 0; i < L; i++) par = par ^ m_bits[i];
                if (L == W) par = 1'b0;
                if (!pv_old || rdy) begin
                    m_msb = wm;
                    m_lsb = wl;
                    m_pv  = 1'b1;
                    m_pe  = par;
                end else begin
                    m_ovr = 1'b1;
                end
                m_bits.delete();
            end
        end
        #1;
        check_all("cyc");
        sin_valid = 1'b0;
        clr       = 1'b0;
    endtask

    // Send one word MSB-first on the wire (plus parity bit when enabled).
    // rdy is held during the word, rdy_last on the final frame bit.
    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last,
                             input int gapmax, input bit bad_par);
        for (int i = 0; i < L; i++) begin
            int gaps;
            bit b;
            gaps = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int g = 0; g < gaps; g++) cycle(1'b0, 1'b0, rdy, 1'b0);
            b = (i < W) ? w[W-1-i] : ((^w) ^ bad_par);
            cycle(1'b1, b, (i == L - 1) ? rdy_last : rdy, 1'b0);
        end
        $display("word %h sent: pout=%h pout_valid=%b overrun=%b parity_err=%b",
                 w, pout_m, pv_m, ovr_m, pe_m);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        #10 rst = 1'b1;

        // 1: A5 MSB-first, consumer always ready: valid for exactly one cycle
        send_word(8'hA5, 1'b1, 1'b1, 0, 1'b0);
        chk("t1_pout", 32'(pout_m), 32'h00A5);
        chk("t1_pv_set", 32'(pv_m), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_pv_one_cycle", 32'(pv_m), 32'h0);

        // 2: single leading one lands at opposite ends per bit order
        send_word(8'h80, 1'b1, 1'b1, 0, 1'b0);
        chk("t2_msb_first", 32'(pout_m), 32'h0080);
        chk("t2_lsb_first", 32'(pout_l), 32'h0001);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // 3: overrun with consumer stalled, clr, then drain
        send_word(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 0, 1'b0);
        chk("t3_pout_kept", 32'(pout_m), 32'h003C);
        chk("t3_overrun", 32'(ovr_m), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr_ovr", 32'(ovr_m), 32'h0);
        chk("t3_clr_pv", 32'(pv_m), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_drained", 32'(pv_m), 32'h0);

        // 4: gapped bits, then back-to-back words accepted on completion edge
        send_word(8'h5A, 1'b1, 1'b1, 3, 1'b0);
        chk("t4_pout", 32'(pout_m), 32'h005A);
        chk("t4_busy_done", 32'(busy_m), 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h12, 1'b0, 1'b1, 0, 1'b0);
        send_word(8'h34, 1'b0, 1'b1, 0, 1'b0);
        chk("t4_b2b_pv", 32'(pv_m), 32'h1);
        chk("t4_b2b_pout", 32'(pout_m), 32'h0034);
        chk("t4_b2b_ovr", 32'(ovr_m), 32'h0);

        // 5: asynchronous reset after 3 bits, then a clean word
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("t5_async_rst");
        chk("t5_pv_zero", 32'(pv_m), 32'h0);
        #2 rst = 1'b1;
        send_word(8'hF0, 1'b1, 1'b1, 0, 1'b0);
        chk("t5_pout", 32'(pout_m), 32'h00F0);
        chk("t5_pout_lsb", 32'(pout_l), 32'h000F);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_PARITY_EN
        // 6: parity good and bad
        send_word(8'hA5, 1'b1, 1'b1, 0, 1'b0);
        chk("t6_perr_good", 32'(pe_m), 32'h0);
        send_word(8'hA5, 1'b1, 1'b1, 0, 1'b1);
        chk("t6_perr_bad", 32'(pe_m), 32'h1);
        chk("t6_pout", 32'(pout_m), 32'h00A5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
